// File: rtl/psg_bus_arbiter.sv
// psg_bus_arbiter
//   Round-robin arbiter that shares the YM2149 PSG register bus among NUM_REQ
//   requesters. Each granted access is sequenced setup -> strobe (write) or
//   setup -> read wait (read) -> recovery gap. This gives every write its own
//   clean wr_n falling edge, so back-to-back envelope-shape writes each restart
//   the envelope.
//
// Ports
//   clk, rst        system clock (rising edge), synchronous active-high reset
//   req_valid/rd    per-requester request and direction (1 = read)
//   req_addr/data   packed per-requester address (4b) and write data (8b)
//   req_ready       one-hot acceptance, only ever asserted in IDLE
//   psg_addr/din    PSG address and write data, held stable across an access
//   psg_cs_n/wr_n   PSG strobes, low together only during a write strobe
//   psg_dout        PSG read data (registered inside the PSG)
//   rsp_valid/id    one-cycle read response pulse and issuing requester
//   rsp_data        captured read data, held until the next read
//   busy            high whenever an access is in progress
//
// state  | meaning
// IDLE   | arbitrate; PSG outputs hold their last values
// SETUP  | addr/din driven, strobes high
// STROBE | cs_n = wr_n = 0 (write only)
// READ   | waiting for the PSG's registered dout; capture on the last cycle
// GAP    | recovery with strobes high, then back to IDLE
module psg_bus_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2,
  parameter int READ_LAT   = 2,
  parameter int GAP_CYC    = 2,
  localparam int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ-1:0]   req_rd,
  input  logic [4*NUM_REQ-1:0] req_addr,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [3:0]           psg_addr,
  output logic [7:0]           psg_din,
  output logic                 psg_cs_n,
  output logic                 psg_wr_n,
  input  logic [7:0]           psg_dout,
  output logic                 rsp_valid,
  output logic [ID_W-1:0]      rsp_id,
  output logic [7:0]           rsp_data,
  output logic                 busy
);

  localparam int MAX_A   = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
  localparam int MAX_B   = (READ_LAT > GAP_CYC) ? READ_LAT : GAP_CYC;
  localparam int MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_STROBE = 3'd2,
    S_READ   = 3'd3,
    S_GAP    = 3'd4
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_init;
  logic              cnt_zero;
  logic [ID_W-1:0]   rr_ptr;
  logic              lat_rd;
  logic [ID_W-1:0]   lat_id;

  logic [NUM_REQ-1:0] grant_oh;
  logic [ID_W-1:0]    grant_id;
  logic               grant_any;
  logic               sel_rd;
  logic [3:0]         sel_addr;
  logic [7:0]         sel_data;
  logic               accept;

  assign cnt_zero = (cnt == '0);

  // First valid requester at or after rr_ptr, searched circularly.
  always_comb begin
    int idx;
    grant_oh  = '0;
    grant_id  = '0;
    grant_any = 1'b0;
    sel_rd    = 1'b0;
    sel_addr  = '0;
    sel_data  = '0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!grant_any && req_valid[idx]) begin
        grant_any     = 1'b1;
        grant_id      = ID_W'(idx);
        grant_oh[idx] = 1'b1;
        sel_rd        = req_rd[idx];
        sel_addr      = req_addr[4*idx +: 4];
        sel_data      = req_data[8*idx +: 8];
      end
    end
  end

  // Ready is masked during reset so nothing can be accepted on a reset edge.
  assign accept = grant_any && (state == S_IDLE) && !rst;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (accept)   state_nxt = S_SETUP;
      S_SETUP:  if (cnt_zero) state_nxt = lat_rd ? S_READ : S_STROBE;
      S_STROBE: if (cnt_zero) state_nxt = S_GAP;
      S_READ:   if (cnt_zero) state_nxt = S_GAP;
      S_GAP:    if (cnt_zero) state_nxt = S_IDLE;
      default:                state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = accept ? grant_oh : '0;
    psg_cs_n  = (state != S_STROBE);
    psg_wr_n  = (state != S_STROBE);
    busy      = (state != S_IDLE);
  end

  // Counter is loaded with length-1 on entry to a timed state and counts to zero.
  always_comb begin
    cnt_init = '0;
    case (state_nxt)
      S_SETUP:  cnt_init = CNT_W'(SETUP_CYC - 1);
      S_STROBE: cnt_init = CNT_W'(STROBE_CYC - 1);
      S_READ:   cnt_init = CNT_W'(READ_LAT - 1);
      S_GAP:    cnt_init = CNT_W'(GAP_CYC - 1);
      default:  cnt_init = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (state_nxt != state) begin
      cnt <= cnt_init;
    end else if (!cnt_zero) begin
      cnt <= cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      psg_addr  <= '0;
      psg_din   <= '0;
      lat_rd    <= 1'b0;
      lat_id    <= '0;
      rr_ptr    <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= 1'b0;
      if (accept) begin
        psg_addr <= sel_addr;
        psg_din  <= sel_data;
        lat_rd   <= sel_rd;
        lat_id   <= grant_id;
        rr_ptr   <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
      end
      // psg_dout has had at least one registered cycle since addr settled.
      if (state == S_READ && cnt_zero) begin
        rsp_data  <= psg_dout;
        rsp_id    <= lat_id;
        rsp_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_psg_bus_arbiter.sv
module tb_psg_bus_arbiter;
  localparam int NR  = 3;
  localparam int SC  = 1;
  localparam int STC = 2;
  localparam int RL  = 2;
  localparam int GC  = 2;
  localparam int IDW = $clog2(NR);
  localparam int LW  = 1 + SC + STC + GC;
  localparam int LR  = 1 + SC + RL + GC;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   req_valid, req_rd, req_ready;
  logic [4*NR-1:0] req_addr;
  logic [8*NR-1:0] req_data;
  logic [3:0]      psg_addr;
  logic [7:0]      psg_din, rsp_data;
  logic [7:0]      psg_dout = 8'h00;
  logic            psg_cs_n, psg_wr_n, rsp_valid, busy;
  logic [IDW-1:0]  rsp_id;

  always #5 clk = ~clk;

  psg_bus_arbiter #(
    .NUM_REQ(NR), .SETUP_CYC(SC), .STROBE_CYC(STC), .READ_LAT(RL), .GAP_CYC(GC)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_rd(req_rd), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready),
    .psg_addr(psg_addr), .psg_din(psg_din), .psg_cs_n(psg_cs_n), .psg_wr_n(psg_wr_n),
    .psg_dout(psg_dout),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy)
  );

  // PSG register file model
  logic [7:0] psg_regs [16] = '{default: 8'h00};
  logic       wr_n_q = 1'b1;
  int         eg_cnt = 0;
  bit         foreign_armed = 1'b0;
  bit         foreign_seen = 1'b0;

  always @(posedge clk) begin
    psg_dout <= psg_regs[psg_addr];
    if (!psg_cs_n && !psg_wr_n) psg_regs[psg_addr] <= psg_din;
    if (wr_n_q && !psg_wr_n && psg_addr == 4'd13) eg_cnt++;
    wr_n_q <= psg_wr_n;
    if (foreign_armed && !psg_cs_n && psg_addr == 4'hA && psg_din == 8'h55) foreign_seen = 1'b1;
  end

  // Requester intent, applied to the DUT on each falling edge
  logic       sh_rst = 1'b0;
  logic       sh_valid [NR] = '{default: 1'b0};
  logic       sh_rd    [NR] = '{default: 1'b0};
  logic [3:0] sh_addr  [NR] = '{default: 4'h0};
  logic [7:0] sh_data  [NR] = '{default: 8'h00};

  // Transaction-level reference: one outstanding access, its age in cycles,
  // and the register contents the PSG should hold after all accepted writes.
  logic [7:0] mem [16] = '{default: 8'h00};
  bit         in_acc = 1'b0;
  bit         prev_rst = 1'b0;
  int         k = 0;
  int         rr = 0;
  bit         acc_rd;
  logic [3:0] acc_addr;
  logic [7:0] acc_data, acc_exp;
  int         acc_id;
  bit         accepted_now;
  int         win_now;
  int         rsp_cnt = 0;
  int         last_rsp_id = -1;
  logic [7:0] last_rsp_data = 8'h00;

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    logic [NR-1:0] exp_ready;
    bit strobe_exp, rv_exp;
    int w;
    @(negedge clk);
    rst = sh_rst;
    for (int i = 0; i < NR; i++) begin
      req_valid[i]      = sh_valid[i];
      req_rd[i]         = sh_rd[i];
      req_addr[4*i +: 4] = sh_addr[i];
      req_data[8*i +: 8] = sh_data[i];
    end
    #1;
    if (prev_rst) begin
      in_acc = 1'b0;
      rr = 0;
      chk("rst_addr", psg_addr, 0);
      chk("rst_din", psg_din, 0);
      chk("rst_rsp_id", rsp_id, 0);
      chk("rst_rsp_data", rsp_data, 0);
    end else if (in_acc) begin
      k++;
      if (k == (acc_rd ? LR : LW)) in_acc = 1'b0;
    end
    strobe_exp = in_acc && !acc_rd && k >= SC + 1 && k <= SC + STC;
    rv_exp     = in_acc && acc_rd && k == SC + RL + 1;
    chk("busy", busy, in_acc);
    chk("cs_n", psg_cs_n, !strobe_exp);
    chk("wr_n", psg_wr_n, !strobe_exp);
    chk("rsp_valid", rsp_valid, rv_exp);
    if (rv_exp) begin
      chk("rsp_id", rsp_id, acc_id);
      chk("rsp_data", rsp_data, acc_exp);
      rsp_cnt++;
      last_rsp_id = int'(rsp_id);
      last_rsp_data = rsp_data;
    end
    if (in_acc) begin
      chk("psg_addr", psg_addr, acc_addr);
      chk("psg_din", psg_din, acc_data);
    end
    exp_ready = '0;
    w = -1;
    if (!in_acc && !sh_rst) begin
      for (int j = 0; j < NR; j++) begin
        int c = (rr + j) % NR;
        if (w < 0 && sh_valid[c]) w = c;
      end
    end
    if (w >= 0) exp_ready[w] = 1'b1;
    chk("req_ready", req_ready, exp_ready);
    accepted_now = (w >= 0);
    if (w >= 0) begin
      in_acc   = 1'b1;
      k        = 0;
      acc_rd   = sh_rd[w];
      acc_addr = sh_addr[w];
      acc_data = sh_data[w];
      acc_id   = w;
      rr       = (w + 1) % NR;
      if (sh_rd[w]) acc_exp = mem[sh_addr[w]];
      else mem[sh_addr[w]] = sh_data[w];
      win_now = w;
      sh_valid[w] = 1'b0;
    end
    prev_rst = sh_rst;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set_req(input int i, input bit rd, input logic [3:0] a, input logic [7:0] d);
    sh_valid[i] = 1'b1;
    sh_rd[i]    = rd;
    sh_addr[i]  = a;
    sh_data[i]  = d;
  endtask

  initial begin
    int last_win, eg0, rsp0, acc_seen;
    bit reissued;
    rst = 1'b1;
    req_valid = '0;
    req_rd = '0;
    req_addr = '0;
    req_data = '0;
    repeat (2) @(posedge clk);
    prev_rst = 1'b1;

    // 1: single write
    set_req(0, 1'b0, 4'd8, 8'h0F);
    steps(LW + 2);
    chk("t1_reg8", psg_regs[8], 8'h0F);

    // 2: two requesters always pending must alternate
    set_req(0, 1'b0, 4'd1, 8'h11);
    set_req(1, 1'b0, 4'd2, 8'h22);
    last_win = -1;
    for (int i = 0; i < 8 * LW; i++) begin
      step();
      if (accepted_now) begin
        if (last_win >= 0) chk("t2_alternate", win_now != last_win, 1);
        last_win = win_now;
        set_req(win_now, 1'b0, 4'($urandom_range(0, 12)), 8'($urandom));
      end
    end
    sh_valid[0] = 1'b0;
    sh_valid[1] = 1'b0;
    steps(LW + 2);

    // 3: read of register 7 by requester 1
    set_req(0, 1'b0, 4'd7, 8'h38);
    steps(LW + 2);
    rsp0 = rsp_cnt;
    set_req(1, 1'b1, 4'd7, 8'h00);
    steps(LR + 2);
    chk("t3_rsp_count", rsp_cnt - rsp0, 1);
    chk("t3_rsp_id", last_rsp_id, 1);
    chk("t3_rsp_data", last_rsp_data, 8'h38);

    // 4: back-to-back envelope-shape writes
    eg0 = eg_cnt;
    reissued = 1'b0;
    set_req(0, 1'b0, 4'd13, 8'h0E);
    for (int i = 0; i < 3 * LW; i++) begin
      step();
      if (accepted_now && !reissued) begin
        reissued = 1'b1;
        set_req(0, 1'b0, 4'd13, 8'h0A);
      end
    end
    chk("t4_eg_restarts", eg_cnt - eg0, 2);
    chk("t4_reg13", psg_regs[13], 8'h0A);

    // 5: reset in the first strobe cycle, then re-issue
    set_req(0, 1'b0, 4'd2, 8'h5A);
    step();
    chk("t5_accept", accepted_now, 1);
    step();
    sh_rst = 1'b1;
    step();
    sh_rst = 1'b0;
    set_req(0, 1'b0, 4'd2, 8'h5A);
    step();
    chk("t5_reaccept", accepted_now && win_now == 0, 1);
    steps(LW + 2);

    // 6: req0 pulses valid while req1 owns the bus
    set_req(1, 1'b0, 4'd3, 8'h33);
    step();
    foreign_armed = 1'b1;
    set_req(0, 1'b0, 4'hA, 8'h55);
    step();
    sh_valid[0] = 1'b0;
    steps(3 * LW);
    chk("t6_no_foreign", foreign_seen, 0);
    foreign_armed = 1'b0;

    // Random traffic with withdrawals
    acc_seen = 0;
    for (int i = 0; i < 4000; i++) begin
      for (int r = 0; r < NR; r++) begin
        if (!sh_valid[r] && $urandom_range(0, 2) == 0)
          set_req(r, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom));
        else if (sh_valid[r] && $urandom_range(0, 19) == 0)
          sh_valid[r] = 1'b0;
      end
      step();
      if (accepted_now) acc_seen++;
    end
    for (int r = 0; r < NR; r++) sh_valid[r] = 1'b0;
    steps(LR + 2);
    chk("rand_progress", acc_seen > 100, 1);
    for (int a = 0; a < 16; a++) chk("final_reg", psg_regs[a], mem[a]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
